uart_letter_rx: RTL and testbench
=================================

UART_LETTER_RX -- requirements
Module: uart_letter_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set clock cycles per UART bit period (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 clk_in  input  1  SHALL be the single system clock; all state SHALL be on its rising edge.
REQ-003 rst_n_in  input  1  SHALL be the reset: asynchronous assert, active-low; deassertion is synchronous to clk_in externally.
REQ-004 uart_rx_in  input  1  SHALL be the asynchronous serial line, 8N1 format, LSB first, idle high.
REQ-005 data_valid_out  output  1  SHALL be a one-cycle strobe marking a new letter code on data_out.
REQ-006 data_out  output  5  SHALL carry the letter code: 0-25 = A-Z, 26 = space.
REQ-007 frame_err_out  output  1  SHALL be a one-cycle strobe on a stop-bit error.

Function
REQ-008 uart_rx_in SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-009 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-010 IDLE: synchronized line low -> START, bit counter cleared.
REQ-011 START: at count CLKS_PER_BIT/2 (integer divide), line high -> IDLE (glitch rejected, no output); line low -> DATA, counter cleared.
REQ-012 DATA: one sample every CLKS_PER_BIT cycles; samples SHALL shift into an 8-bit register LSB first; after the 8th sample -> STOP.
REQ-013 STOP: sample after CLKS_PER_BIT cycles; line high -> byte accepted, -> IDLE; line low -> frame_err_out pulse, byte discarded, -> WAIT_HIGH.
REQ-014 WAIT_HIGH: remain until synchronized line high, then -> IDLE; a held-low break SHALL produce exactly one frame_err_out pulse.
REQ-015 Mapping of accepted byte b: 0x41..0x5A -> b-0x41; 0x61..0x7A -> b-0x61; 0x20 -> 26; any other byte SHALL be dropped silently (no strobe).
REQ-016 data_valid_out SHALL assert exactly one cycle, in the cycle after the stop-bit sample clock edge (latency 1 cycle from stop sample).
REQ-017 data_out SHALL update only with a data_valid_out strobe and SHALL hold its value otherwise.
REQ-018 data_valid_out and frame_err_out SHALL never assert in the same cycle.
REQ-019 Baud counter width SHALL be $clog2(CLKS_PER_BIT)+1 bits; counter SHALL never wrap within a bit period.
REQ-020 Back-to-back frames (next start bit immediately after stop bit) SHALL be received without loss; the receiver SHALL be in IDLE no later than the stop-bit center.
REQ-021 No backpressure: the consumer SHALL accept every strobe; strobes are at least 10*CLKS_PER_BIT cycles apart.

Reset
REQ-022 While rst_n_in low: state IDLE, counters 0, shift register 0, synchronizer flops 1, data_valid_out 0, data_out 0, frame_err_out 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no strobe; after release, the remainder of the aborted frame SHALL be handled as fresh line activity (a low bit may start a new frame).
REQ-024 First strobe after reset release SHALL require a complete valid frame starting from IDLE.

Verification (CLKS_PER_BIT = 16)
REQ-025 Send 0x48 ('H') -> one data_valid_out pulse, data_out = 7, one cycle after the stop sample; frame_err_out stays 0.
REQ-026 Send 0x7A, 0x20, 0x41 back-to-back -> three pulses with data_out = 25, 26, 0 in order, none lost.
REQ-027 Send 0x31 ('1') then 0x62 -> exactly one pulse, data_out = 1.
REQ-028 Send 0x41 with stop bit forced low, then hold the line low 40 bit times -> exactly one frame_err_out pulse, no data_valid_out; after the line returns high, 0x43 -> data_out = 2.
REQ-029 Low glitch of 4 cycles on an idle line -> no strobes, FSM back in IDLE; a following 0x4B -> data_out = 10.
REQ-030 Assert rst_n_in during bit 3 of 0x5A -> all outputs 0 immediately (asynchronous); after release, a full 0x45 -> data_out = 4, no strobe from the aborted frame.

Source files
------------

// File: rtl/uart_letter_rx.sv
// 8N1 UART receiver that converts ASCII letters and space into 5-bit letter codes
// (A-Z/a-z -> 0..25, space -> 26). Other bytes are dropped; bad stop bits pulse frame_err_out.
module uart_letter_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       uart_rx_in,
    output logic       data_valid_out,
    output logic [4:0] data_out,
    output logic       frame_err_out
);

    localparam int               CNT_W       = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_CNT    = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam int               SYNC_STAGES = 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   rx_bit;

    logic [2:0]       state_reg,      state_next;
    logic [CNT_W-1:0] cnt_reg,        cnt_next;
    logic [2:0]       bit_idx_reg,    bit_idx_next;
    logic [7:0]       shift_reg,      shift_next;
    logic             data_valid_reg, data_valid_next;
    logic [4:0]       data_reg,       data_next;
    logic             frame_err_reg,  frame_err_next;

    logic             map_hit;
    logic [4:0]       map_code;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : gen_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = uart_rx_in;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign rx_bit = sync_reg[SYNC_STAGES-1];

    // Upper- and lower-case letters share the same low five bits (1..26 for A..Z).
    always_comb begin
        map_hit  = 1'b0;
        map_code = 5'd0;
        if ((shift_reg >= 8'h41 && shift_reg <= 8'h5A) ||
            (shift_reg >= 8'h61 && shift_reg <= 8'h7A)) begin
            map_hit  = 1'b1;
            map_code = shift_reg[4:0] - 5'd1;
        end else if (shift_reg == 8'h20) begin
            map_hit  = 1'b1;
            map_code = 5'd26;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        data_valid_next = 1'b0;
        data_next       = data_reg;
        frame_err_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!rx_bit) begin
                    state_next   = ST_START;
                    cnt_next     = '0;
                    bit_idx_next = 3'd0;
                end
            end

            // A start bit that is high again at its centre was a glitch.
            ST_START: begin
                if (cnt_reg == HALF_CNT) begin
                    cnt_next   = '0;
                    state_next = rx_bit ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next   = '0;
                    shift_next = {rx_bit, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            // Leaving at the stop-bit centre leaves half a bit to catch a following start bit.
            ST_STOP: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next = '0;
                    if (rx_bit) begin
                        state_next = ST_IDLE;
                        if (map_hit) begin
                            data_valid_next = 1'b1;
                            data_next       = map_code;
                        end
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            ST_WAIT_HIGH: begin
                if (rx_bit) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_reg       <= '1;
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= 3'd0;
            shift_reg      <= 8'd0;
            data_valid_reg <= 1'b0;
            data_reg       <= 5'd0;
            frame_err_reg  <= 1'b0;
        end else begin
            sync_reg       <= sync_next;
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            data_valid_reg <= data_valid_next;
            data_reg       <= data_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    assign data_valid_out = data_valid_reg;
    assign data_out       = data_reg;
    assign frame_err_out  = frame_err_reg;

endmodule

// File: tb/tb_uart_letter_rx.sv
// Bench for uart_letter_rx: drives bit-aligned 8N1 frames and compares every strobe
// against directed expectations or a slot-level frame decoding model.
module tb_uart_letter_rx;

    localparam int CLKS    = 16;
    // Stop bit is sampled near its centre, then seen through the synchronizer and output register.
    localparam int LAT_MIN = CLKS / 2;
    localparam int LAT_MAX = CLKS / 2 + 4;

    logic       clk_in     = 1'b0;
    logic       rst_n_in   = 1'b0;
    logic       uart_rx_in = 1'b1;
    logic       data_valid_out;
    logic [4:0] data_out;
    logic       frame_err_out;

    uart_letter_rx #(.CLKS_PER_BIT(CLKS)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .uart_rx_in     (uart_rx_in),
        .data_valid_out (data_valid_out),
        .data_out       (data_out),
        .frame_err_out  (frame_err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { bit is_err; int code; int cyc; } ev_t;
    typedef struct { bit b; bit is_stop; } slot_t;

    int         asserts   = 0;
    int         failures  = 0;
    int         cyc       = 0;
    int         both_seen = 0;
    int         hold_viol = 0;
    logic [4:0] prev_data = 5'd0;
    ev_t        obs_q[$];
    ev_t        exp_q[$];
    slot_t      pend_q[$];
    bit         slot_bits[$];
    int         slot_cyc[$];
    int         stop_cyc[$];

    function automatic ev_t mk_ev(bit e, int c, int t);
        ev_t v;
        v.is_err = e;
        v.code   = c;
        v.cyc    = t;
        return v;
    endfunction

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (data_valid_out && frame_err_out) both_seen <= both_seen + 1;
        if (data_valid_out) begin
            obs_q.push_back(mk_ev(1'b0, int'(data_out), cyc));
            $display("[cyc %0d] strobe data_out=%0d", cyc, data_out);
        end
        if (frame_err_out) begin
            obs_q.push_back(mk_ev(1'b1, 0, cyc));
            $display("[cyc %0d] frame error strobe", cyc);
        end
        if (rst_n_in && !data_valid_out && data_out !== prev_data) hold_viol <= hold_viol + 1;
        prev_data <= data_out;
    end

    task automatic push_bit(bit b, bit s);
        slot_t x;
        x.b       = b;
        x.is_stop = s;
        pend_q.push_back(x);
    endtask

    task automatic push_idle(int n);
        repeat (n) push_bit(1'b1, 1'b0);
    endtask

    task automatic push_byte(logic [7:0] v, bit stop);
        push_bit(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) push_bit(v[k], 1'b0);
        push_bit(stop, 1'b1);
    endtask

    task automatic drive_slots();
        slot_t x;
        while (pend_q.size() > 0) begin
            x = pend_q.pop_front();
            @(negedge clk_in);
            uart_rx_in = x.b;
            slot_bits.push_back(x.b);
            slot_cyc.push_back(cyc);
            if (x.is_stop) stop_cyc.push_back(cyc);
            repeat (CLKS - 1) @(negedge clk_in);
        end
    endtask

    task automatic clear_all();
        obs_q.delete();
        exp_q.delete();
        pend_q.delete();
        slot_bits.delete();
        slot_cyc.delete();
        stop_cyc.delete();
    endtask

    // Frame-level decoding of the driven bit slots, straight from the 8N1 and letter rules.
    task automatic run_model();
        int i;
        int n;
        int v;
        i = 0;
        n = slot_bits.size();
        exp_q.delete();
        while (i < n) begin
            if (slot_bits[i] == 1'b0 && i + 9 < n) begin
                v = 0;
                for (int k = 0; k < 8; k++) v += int'(slot_bits[i + 1 + k]) << k;
                if (slot_bits[i + 9]) begin
                    if (v >= 65 && v <= 90)       exp_q.push_back(mk_ev(1'b0, v - 65, slot_cyc[i + 9]));
                    else if (v >= 97 && v <= 122) exp_q.push_back(mk_ev(1'b0, v - 97, slot_cyc[i + 9]));
                    else if (v == 32)             exp_q.push_back(mk_ev(1'b0, 26, slot_cyc[i + 9]));
                    i += 10;
                end else begin
                    exp_q.push_back(mk_ev(1'b1, 0, slot_cyc[i + 9]));
                    i += 10;
                    while (i < n && slot_bits[i] == 1'b0) i++;
                end
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n_in   = 1'b0;
        uart_rx_in = 1'b1;
        repeat (4) @(negedge clk_in);
        asserts++;
        if (data_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset data_valid_out: got %b, expected 0", data_valid_out);
        end
        asserts++;
        if (frame_err_out !== 1'b0) begin
            failures++;
            $display("FAIL reset frame_err_out: got %b, expected 0", frame_err_out);
        end
        asserts++;
        if (data_out !== 5'd0) begin
            failures++;
            $display("FAIL reset data_out: got %0d, expected 0", data_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        clear_all();
        repeat (40) @(negedge clk_in);
        asserts++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL reset idle: got %0d strobes on idle line, expected 0", obs_q.size());
        end
    endtask

    task automatic test_single();
        clear_all();
        push_idle(1);
        push_byte(8'h48, 1'b1);
        push_idle(2);
        drive_slots();
        exp_q.push_back(mk_ev(1'b0, 7, stop_cyc[0]));
        asserts++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL single count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            asserts++;
            if (obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].code !== exp_q[i].code) begin
                failures++;
                $display("FAIL single ev%0d: got err=%0d code=%0d, expected err=%0d code=%0d",
                         i, obs_q[i].is_err, obs_q[i].code, exp_q[i].is_err, exp_q[i].code);
            end
            asserts++;
            if (obs_q[i].cyc - exp_q[i].cyc < LAT_MIN || obs_q[i].cyc - exp_q[i].cyc > LAT_MAX) begin
                failures++;
                $display("FAIL single ev%0d timing: got %0d cycles after stop start, expected %0d..%0d",
                         i, obs_q[i].cyc - exp_q[i].cyc, LAT_MIN, LAT_MAX);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        push_idle(1);
        push_byte(8'h7A, 1'b1);
        push_byte(8'h20, 1'b1);
        push_byte(8'h41, 1'b1);
        push_idle(2);
        drive_slots();
        exp_q.push_back(mk_ev(1'b0, 25, stop_cyc[0]));
        exp_q.push_back(mk_ev(1'b0, 26, stop_cyc[1]));
        exp_q.push_back(mk_ev(1'b0, 0, stop_cyc[2]));
        asserts++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL b2b count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            asserts++;
            if (obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].code !== exp_q[i].code) begin
                failures++;
                $display("FAIL b2b ev%0d: got err=%0d code=%0d, expected err=%0d code=%0d",
                         i, obs_q[i].is_err, obs_q[i].code, exp_q[i].is_err, exp_q[i].code);
            end
            asserts++;
            if (obs_q[i].cyc - exp_q[i].cyc < LAT_MIN || obs_q[i].cyc - exp_q[i].cyc > LAT_MAX) begin
                failures++;
                $display("FAIL b2b ev%0d timing: got %0d cycles after stop start, expected %0d..%0d",
                         i, obs_q[i].cyc - exp_q[i].cyc, LAT_MIN, LAT_MAX);
            end
        end
    endtask

    task automatic test_non_letter();
        clear_all();
        push_idle(1);
        push_byte(8'h31, 1'b1);
        push_idle(1);
        push_byte(8'h62, 1'b1);
        push_idle(2);
        drive_slots();
        exp_q.push_back(mk_ev(1'b0, 1, stop_cyc[1]));
        asserts++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL nonletter count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            asserts++;
            if (obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].code !== exp_q[i].code) begin
                failures++;
                $display("FAIL nonletter ev%0d: got err=%0d code=%0d, expected err=%0d code=%0d",
                         i, obs_q[i].is_err, obs_q[i].code, exp_q[i].is_err, exp_q[i].code);
            end
        end
    endtask

    task automatic test_framing_break();
        clear_all();
        push_idle(1);
        push_byte(8'h41, 1'b0);
        repeat (40) push_bit(1'b0, 1'b0);
        push_idle(2);
        push_byte(8'h43, 1'b1);
        push_idle(2);
        drive_slots();
        exp_q.push_back(mk_ev(1'b1, 0, stop_cyc[0]));
        exp_q.push_back(mk_ev(1'b0, 2, stop_cyc[1]));
        asserts++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL framing count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            asserts++;
            if (obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].code !== exp_q[i].code) begin
                failures++;
                $display("FAIL framing ev%0d: got err=%0d code=%0d, expected err=%0d code=%0d",
                         i, obs_q[i].is_err, obs_q[i].code, exp_q[i].is_err, exp_q[i].code);
            end
            asserts++;
            if (obs_q[i].cyc - exp_q[i].cyc < LAT_MIN || obs_q[i].cyc - exp_q[i].cyc > LAT_MAX) begin
                failures++;
                $display("FAIL framing ev%0d timing: got %0d cycles after stop start, expected %0d..%0d",
                         i, obs_q[i].cyc - exp_q[i].cyc, LAT_MIN, LAT_MAX);
            end
        end
    endtask

    task automatic test_glitch();
        clear_all();
        push_idle(1);
        drive_slots();
        @(negedge clk_in);
        uart_rx_in = 1'b0;
        repeat (4) @(negedge clk_in);
        uart_rx_in = 1'b1;
        repeat (31) @(negedge clk_in);
        asserts++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL glitch strobes: got %0d events after glitch, expected 0", obs_q.size());
        end
        push_byte(8'h4B, 1'b1);
        push_idle(2);
        drive_slots();
        exp_q.push_back(mk_ev(1'b0, 10, stop_cyc[0]));
        asserts++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL glitch count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            asserts++;
            if (obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].code !== exp_q[i].code) begin
                failures++;
                $display("FAIL glitch ev%0d: got err=%0d code=%0d, expected err=%0d code=%0d",
                         i, obs_q[i].is_err, obs_q[i].code, exp_q[i].is_err, exp_q[i].code);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] z;
        z = 8'h5A;
        clear_all();
        push_idle(1);
        push_bit(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) push_bit(z[k], 1'b0);
        drive_slots();
        @(negedge clk_in);
        uart_rx_in = z[3];
        repeat (5) @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        asserts++;
        if (data_valid_out !== 1'b0 || frame_err_out !== 1'b0) begin
            failures++;
            $display("FAIL midreset strobes: got valid=%b err=%b, expected 0 0", data_valid_out, frame_err_out);
        end
        asserts++;
        if (data_out !== 5'd0) begin
            failures++;
            $display("FAIL midreset data_out: got %0d, expected 0", data_out);
        end
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (7) @(negedge clk_in);
        for (int k = 4; k < 8; k++) push_bit(z[k], 1'b0);
        push_bit(1'b1, 1'b0);
        push_idle(10);
        push_byte(8'h45, 1'b1);
        push_idle(2);
        drive_slots();
        exp_q.push_back(mk_ev(1'b0, 4, stop_cyc[0]));
        asserts++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL midreset count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            asserts++;
            if (obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].code !== exp_q[i].code) begin
                failures++;
                $display("FAIL midreset ev%0d: got err=%0d code=%0d, expected err=%0d code=%0d",
                         i, obs_q[i].is_err, obs_q[i].code, exp_q[i].is_err, exp_q[i].code);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        bit         stop;
        clear_all();
        push_idle(2);
        for (int f = 0; f < 24; f++) begin
            case ($urandom_range(0, 3))
                0:       v = 8'(8'h41 + $urandom_range(0, 25));
                1:       v = 8'(8'h61 + $urandom_range(0, 25));
                2:       v = 8'h20;
                default: v = 8'($urandom_range(0, 255));
            endcase
            stop = ($urandom_range(0, 7) != 0);
            push_byte(v, stop);
            if (!stop) begin
                repeat ($urandom_range(0, 3)) push_bit(1'b0, 1'b0);
                push_idle(1);
            end
            push_idle($urandom_range(0, 2));
        end
        push_idle(2);
        drive_slots();
        run_model();
        asserts++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL random count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            asserts++;
            if (obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].code !== exp_q[i].code) begin
                failures++;
                $display("FAIL random ev%0d: got err=%0d code=%0d, expected err=%0d code=%0d",
                         i, obs_q[i].is_err, obs_q[i].code, exp_q[i].is_err, exp_q[i].code);
            end
            asserts++;
            if (obs_q[i].cyc - exp_q[i].cyc < LAT_MIN || obs_q[i].cyc - exp_q[i].cyc > LAT_MAX) begin
                failures++;
                $display("FAIL random ev%0d timing: got %0d cycles after stop start, expected %0d..%0d",
                         i, obs_q[i].cyc - exp_q[i].cyc, LAT_MIN, LAT_MAX);
            end
        end
    endtask

    task automatic test_invariants();
        asserts++;
        if (both_seen !== 0) begin
            failures++;
            $display("FAIL overlap: valid and frame error together in %0d cycles, expected 0", both_seen);
        end
        asserts++;
        if (hold_viol !== 0) begin
            failures++;
            $display("FAIL hold: data_out changed without strobe %0d times, expected 0", hold_viol);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_non_letter();
        test_framing_break();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
